div_unit: RTL and testbench
===========================

# div_unit

Iterative DIV/IDIV unit for the 8088 core, beside the single-cycle ALU on the execution datapath. The ALU produces results in one clock; this block accepts a divide request from the microsequencer, holds it across several cycles with a start/busy/done handshake, and returns quotient, remainder and a divide-error indication. It covers byte (AX ÷ r/m8) and word (DX:AX ÷ r/m16) forms, unsigned and signed.

## Interface
Parameters: none; iteration counts are package constants.
- CLKx4  in  1  core clock; all state changes on its rising edge
- RESET  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- byteWord  in  1  0 = byte form, 1 = word form (same encoding as the ALU)
- signedOp  in  1  0 = DIV, 1 = IDIV
- dividendHi  in  16  DX (word form); ignored in byte form
- dividendLo  in  16  AX; the full dividend in byte form
- divisor  in  16  divisor; byte form uses [7:0]
- busy  out  1  request in progress
- done  out  1  one-cycle completion pulse
- divError  out  1  valid with done; 1 = divide error (INT 0 required)
- quotient  out  16  byte form: AL in [7:0], [15:8] = 0
- remainder  out  16  byte form: AH in [7:0], [15:8] = 0

## Operation
- States: IDLE, SETUP, ITER, FIX, DONE.
- IDLE: when start = 1, capture all inputs and go to SETUP. start is ignored in every other state.
- SETUP:
  - Signed: take magnitudes of dividend and divisor; record quotient sign (dividend sign XOR divisor sign) and remainder sign (dividend sign).
  - Error if divisor = 0, or if the high half of the dividend magnitude ≥ divisor magnitude. High half is [15:8] in byte form, DX in word form. On error go to DONE with error flag set; otherwise go to ITER.
- ITER: one restoring shift/subtract step per cycle. 8 steps (byte) or 16 steps (word), counted by a 5-bit counter. Go to FIX after the last step.
- FIX:
  - Signed: negate quotient and remainder per the recorded signs.
  - 8088 range check on the signed quotient: −127..+127 (byte), −32767..+32767 (word). −128 and −32768 are errors.
- DONE: for one cycle, assert done and set divError.
  - No error: update quotient and remainder.
  - Error: quotient and remainder hold their previous values.
  - Then return to IDLE.
- Quotient and remainder change only at the DONE edge or on reset.
- RESET at any time, including mid-ITER: state = IDLE, busy = 0, done = 0, divError = 0, quotient = 0, remainder = 0, and the captured request is discarded.

## Timing
- E0 is the edge that samples start in IDLE.
- SETUP covers E0→E1; ITER covers E1..E(N+1); FIX ends at E(N+2); done rises at E(N+3).
- Latency from start to done: 11 edges for byte (N = 8), 19 edges for word (N = 16).
- Error detected in SETUP: done rises at E2.
- busy is high from E1 and falls at the same edge done rises.
- A new start may be issued in the cycle where done = 1; it is sampled at the next edge.
- Outputs are all registered; no combinational input-to-output path.

## Structure
- Package div_pkg holds:
  - state enum (IDLE, SETUP, ITER, FIX, DONE)
  - ITER_BYTE = 8, ITER_WORD = 16
  - the signed quotient limits
- One combinational sub-module, div_step, performs a single restoring step:
  - inputs: partial remainder, next dividend bit, divisor
  - outputs: new partial remainder, quotient bit
- The top level holds the FSM, counter, sign logic and output registers.

## Test plan
- Unsigned byte: AX = 0x0064, divisor = 0x0007 → quotient = 0x000E, remainder = 0x0002, divError = 0, done at E11, busy high E1..E10.
- Unsigned word: DX:AX = 0x0001:0x0000, divisor = 0x0002 → quotient = 0x8000, remainder = 0x0000, done at E19.
- Signed byte: AX = 0xFFF9 (−7), divisor = 0x02 → quotient = 0x00FD (−3), remainder = 0x00FF (−1), done at E11.
- Divide by zero after a good result:
  - Issue any dividend with divisor = 0.
  - Expect done and divError at E2; quotient and remainder unchanged from the previous result.
- 8088 IDIV limit and unsigned overflow:
  - AX = 0xFF80 (−128), divisor = 0x01, IDIV byte → divError = 1 at E11.
  - DIV byte, AX = 0x0500, divisor = 0x05 → divError = 1 at E2.
- Reset mid-operation, then restart:
  - Assert RESET at E5 of a word divide → busy = 0, done = 0, divError = 0, quotient = 0, remainder = 0 at E6.
  - No done pulse follows.
  - A fresh start completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative DIV/IDIV unit.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ITER  = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } divState_t;

    localparam logic [4:0] ITER_BYTE = 5'd8;
    localparam logic [4:0] ITER_WORD = 5'd16;

    // Largest signed quotient magnitude the 8088 accepts; -128 / -32768 trap.
    localparam logic [15:0] QMAX_BYTE = 16'd127;
    localparam logic [15:0] QMAX_WORD = 16'd32767;

endpackage

// File: rtl/div_unit_step.sv
// One restoring shift/subtract step of an unsigned division.
// The caller guarantees partRem < divisor, so newRem always fits 16 bits.
module div_step (
    input  logic [15:0] partRem,
    input  logic        nextBit,
    input  logic [15:0] divisor,
    output logic [15:0] newRem,
    output logic        qBit
);

    logic [16:0] trial;
    logic [16:0] diff;

    // Shift in the next dividend bit and keep the difference if it did not borrow.
    always_comb begin
        trial  = {partRem, nextBit};
        diff   = trial - {1'b0, divisor};
        qBit   = ~diff[16];
        newRem = qBit ? diff[15:0] : trial[15:0];
    end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/IDIV unit: byte (AX / r/m8) and word (DX:AX / r/m16) forms.
//
// Handshake: start is sampled only in IDLE; busy rises one edge later and
// falls on the edge where done pulses for exactly one cycle. divError is
// meaningful while done is high. A new start may be driven during the done
// cycle. quotient/remainder change only on the done edge (when no error)
// or on reset.
module div_unit
    import div_pkg::*;
(
    input  logic        CLKx4,
    input  logic        RESET,
    input  logic        start,
    input  logic        byteWord,
    input  logic        signedOp,
    input  logic [15:0] dividendHi,
    input  logic [15:0] dividendLo,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        divError,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output divState_t   stateDbg
);

    divState_t   state;
    logic        isWord, isSigned;
    logic [15:0] capHi, capLo, capDiv;
    logic [15:0] remReg, dqReg, divMag;
    logic [4:0]  count;
    logic        qNeg, rNeg, errFlag;
    logic [15:0] resQ, resR;

    // Setup-stage combinational values derived from the captured request
    logic        dvdSign, divSign;
    logic [31:0] dvdRaw, dvdMag;
    logic [15:0] hiHalf, loHalf, divMagC;
    logic [7:0]  divByteNeg;
    logic        setupErr;

    // Fix-stage combinational values
    logic [15:0] qSigned, rSigned, qLimit, qFinal, rFinal;
    logic        fixErr;

    // Step datapath
    logic [15:0] stepRem;
    logic        stepBit;

    div_step u_step (
        .partRem (remReg),
        .nextBit (dqReg[15]),
        .divisor (divMag),
        .newRem  (stepRem),
        .qBit    (stepBit)
    );

    // Magnitudes, signs and the early overflow / divide-by-zero check.
    always_comb begin
        dvdSign    = isWord ? capHi[15] : capLo[15];
        divSign    = isWord ? capDiv[15] : capDiv[7];
        dvdRaw     = isWord ? {capHi, capLo} : {16'h0000, capLo};
        dvdMag     = (isSigned && dvdSign) ? (~dvdRaw + 32'd1) : dvdRaw;
        divByteNeg = ~capDiv[7:0] + 8'd1;
        if (isWord)
            divMagC = (isSigned && divSign) ? (~capDiv + 16'd1) : capDiv;
        else
            divMagC = {8'h00, (isSigned && divSign) ? divByteNeg : capDiv[7:0]};
        // Byte form left-aligns the low dividend byte so the step always shifts from bit 15.
        hiHalf   = isWord ? dvdMag[31:16] : {8'h00, dvdMag[15:8]};
        loHalf   = isWord ? dvdMag[15:0]  : {dvdMag[7:0], 8'h00};
        setupErr = (divMagC == 16'h0000) || (hiHalf >= divMagC);
    end

    // Apply signs and the 8088 signed quotient range check.
    always_comb begin
        qSigned = qNeg ? (~dqReg + 16'd1) : dqReg;
        rSigned = rNeg ? (~remReg + 16'd1) : remReg;
        qLimit  = isWord ? QMAX_WORD : QMAX_BYTE;
        fixErr  = isSigned && (dqReg > qLimit);
        qFinal  = isWord ? qSigned : {8'h00, qSigned[7:0]};
        rFinal  = isWord ? rSigned : {8'h00, rSigned[7:0]};
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge CLKx4) begin
        if (RESET) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            divError  <= 1'b0;
            quotient  <= 16'h0000;
            remainder <= 16'h0000;
            isWord    <= 1'b0;
            isSigned  <= 1'b0;
            capHi     <= 16'h0000;
            capLo     <= 16'h0000;
            capDiv    <= 16'h0000;
            remReg    <= 16'h0000;
            dqReg     <= 16'h0000;
            divMag    <= 16'h0000;
            count     <= 5'd0;
            qNeg      <= 1'b0;
            rNeg      <= 1'b0;
            errFlag   <= 1'b0;
            resQ      <= 16'h0000;
            resR      <= 16'h0000;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        isWord   <= byteWord;
                        isSigned <= signedOp;
                        capHi    <= dividendHi;
                        capLo    <= dividendLo;
                        capDiv   <= divisor;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    busy    <= 1'b1;
                    remReg  <= hiHalf;
                    dqReg   <= loHalf;
                    divMag  <= divMagC;
                    count   <= isWord ? ITER_WORD : ITER_BYTE;
                    qNeg    <= isSigned & (dvdSign ^ divSign);
                    rNeg    <= isSigned & dvdSign;
                    errFlag <= setupErr;
                    state   <= setupErr ? DONE : ITER;
                end
                ITER: begin
                    remReg <= stepRem;
                    dqReg  <= {dqReg[14:0], stepBit};
                    count  <= count - 5'd1;
                    if (count == 5'd1)
                        state <= FIX;
                end
                FIX: begin
                    resQ    <= qFinal;
                    resR    <= rFinal;
                    errFlag <= fixErr;
                    state   <= DONE;
                end
                DONE: begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    divError <= errFlag;
                    if (!errFlag) begin
                        quotient  <= resQ;
                        remainder <= resR;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stateDbg = state;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus reset and start-while-busy sequences.
module tb_div_unit;
    import div_pkg::*;

    logic        CLKx4 = 1'b0;
    logic        RESET;
    logic        start;
    logic        byteWord;
    logic        signedOp;
    logic [15:0] dividendHi;
    logic [15:0] dividendLo;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic        divError;
    logic [15:0] quotient;
    logic [15:0] remainder;
    divState_t   stateDbg;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        bw;
        logic        sg;
        logic [15:0] hi;
        logic [15:0] lo;
        logic [15:0] dv;
        logic [15:0] q;
        logic [15:0] r;
        logic        err;
        int          edgeN;
    } vec_t;

    vec_t vecs[13];

    logic [15:0] lastQ;
    logic [15:0] lastR;

    // clock / reset
    always #5 CLKx4 = ~CLKx4;

    div_unit dut (
        .CLKx4      (CLKx4),
        .RESET      (RESET),
        .start      (start),
        .byteWord   (byteWord),
        .signedOp   (signedOp),
        .dividendHi (dividendHi),
        .dividendLo (dividendLo),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .divError   (divError),
        .quotient   (quotient),
        .remainder  (remainder),
        .stateDbg   (stateDbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issue one request and count edges (E0 = sampling edge) until done.
    task automatic run_op(input logic bw, input logic sg, input logic [15:0] hi,
                          input logic [15:0] lo, input logic [15:0] dv,
                          output int doneEdge, output int busyBad);
        @(negedge CLKx4);
        start      = 1'b1;
        byteWord   = bw;
        signedOp   = sg;
        dividendHi = hi;
        dividendLo = lo;
        divisor    = dv;
        @(posedge CLKx4);
        #1;
        start    = 1'b0;
        doneEdge = -1;
        busyBad  = 0;
        if (busy || done) busyBad++;
        for (int k = 1; k <= 40 && doneEdge < 0; k++) begin
            @(posedge CLKx4);
            #1;
            if (done) begin
                doneEdge = k;
                if (busy) busyBad++;
            end else if (!busy) begin
                busyBad++;
            end
        end
    endtask

    initial begin
        int dEdge;
        int bBad;
        int doneCount;
        logic [15:0] expQ;
        logic [15:0] expR;

        //                bw    sg    hi        lo        dv        q         r         err   edge
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 11};
        vecs[1]  = '{1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0002, 16'h8000, 16'h0000, 1'b0, 19};
        vecs[2]  = '{1'b0, 1'b1, 16'h0000, 16'hFFF9, 16'h0002, 16'h00FD, 16'h00FF, 1'b0, 11};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b1, 2};
        vecs[4]  = '{1'b0, 1'b1, 16'h0000, 16'hFF80, 16'h0001, 16'h0000, 16'h0000, 1'b1, 11};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 16'h0500, 16'h0005, 16'h0000, 16'h0000, 1'b1, 2};
        vecs[6]  = '{1'b1, 1'b1, 16'hFFFF, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 19};
        vecs[7]  = '{1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'h0100, 16'h00FF, 16'h00FF, 1'b0, 19};
        vecs[8]  = '{1'b0, 1'b1, 16'h0000, 16'h0064, 16'h00F9, 16'h00F2, 16'h0002, 1'b0, 11};
        vecs[9]  = '{1'b1, 1'b1, 16'h0000, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 1'b1, 19};
        vecs[10] = '{1'b1, 1'b1, 16'hFFFF, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 1'b1, 19};
        vecs[11] = '{1'b0, 1'b0, 16'hABCD, 16'h0010, 16'hFF03, 16'h0005, 16'h0001, 1'b0, 11};
        vecs[12] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 2};

        RESET = 1'b1; start = 1'b0; byteWord = 1'b0; signedOp = 1'b0;
        dividendHi = 16'h0; dividendLo = 16'h0; divisor = 16'h0;
        repeat (3) @(posedge CLKx4);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(divError), 32'd0);
        check("reset_q", 32'(quotient), 32'd0);
        check("reset_r", 32'(remainder), 32'd0);
        check("reset_state", 32'(stateDbg), 32'(IDLE));
        @(negedge CLKx4);
        RESET = 1'b0;
        lastQ = 16'h0000;
        lastR = 16'h0000;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].bw, vecs[i].sg, vecs[i].hi, vecs[i].lo, vecs[i].dv, dEdge, bBad);
            expQ = vecs[i].err ? lastQ : vecs[i].q;
            expR = vecs[i].err ? lastR : vecs[i].r;
            check($sformatf("v%0d_edge", i), 32'(dEdge), 32'(vecs[i].edgeN));
            check($sformatf("v%0d_busy", i), 32'(bBad), 32'd0);
            check($sformatf("v%0d_err", i), 32'(divError), 32'(vecs[i].err));
            check($sformatf("v%0d_q", i), 32'(quotient), 32'(expQ));
            check($sformatf("v%0d_r", i), 32'(remainder), 32'(expR));
            lastQ = expQ;
            lastR = expR;
        end

        // start pulsed while busy must be ignored; inputs changed after E0 must not matter
        @(negedge CLKx4);
        start = 1'b1; byteWord = 1'b0; signedOp = 1'b0;
        dividendHi = 16'h0; dividendLo = 16'h00C8; divisor = 16'h000A;
        @(posedge CLKx4);
        #1;
        start = 1'b0;
        dEdge = -1;
        doneCount = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 3) begin
                start = 1'b1; byteWord = 1'b1; dividendLo = 16'h0005; divisor = 16'h0001;
            end else begin
                start = 1'b0;
            end
            @(posedge CLKx4);
            #1;
            if (done) begin
                doneCount++;
                if (dEdge < 0) dEdge = k;
            end
            if (dEdge == k) begin
                check("ign_q", 32'(quotient), 32'h0014);
                check("ign_r", 32'(remainder), 32'h0000);
                check("ign_err", 32'(divError), 32'd0);
            end
        end
        check("ign_edge", 32'(dEdge), 32'd11);
        check("ign_done_count", 32'(doneCount), 32'd1);
        lastQ = 16'h0014;
        lastR = 16'h0000;

        // reset sampled at E5 of a word divide
        @(negedge CLKx4);
        start = 1'b1; byteWord = 1'b1; signedOp = 1'b0;
        dividendHi = 16'h0000; dividendLo = 16'h1234; divisor = 16'h0003;
        @(posedge CLKx4);
        #1;
        start = 1'b0;
        repeat (4) @(posedge CLKx4);
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        @(negedge CLKx4);
        RESET = 1'b1;
        @(posedge CLKx4);
        #1;
        check("rst5_busy", 32'(busy), 32'd0);
        check("rst5_q", 32'(quotient), 32'd0);
        check("rst5_state", 32'(stateDbg), 32'(IDLE));
        @(negedge CLKx4);
        RESET = 1'b0;
        @(posedge CLKx4);
        #1;
        check("rst6_busy", 32'(busy), 32'd0);
        check("rst6_done", 32'(done), 32'd0);
        check("rst6_err", 32'(divError), 32'd0);
        check("rst6_q", 32'(quotient), 32'd0);
        check("rst6_r", 32'(remainder), 32'd0);
        doneCount = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge CLKx4);
            #1;
            if (done || busy) doneCount++;
        end
        check("rst_no_done", 32'(doneCount), 32'd0);

        // fresh start after reset completes normally
        run_op(1'b0, 1'b0, 16'h0000, 16'h0064, 16'h0007, dEdge, bBad);
        check("post_rst_edge", 32'(dEdge), 32'd11);
        check("post_rst_busy", 32'(bBad), 32'd0);
        check("post_rst_err", 32'(divError), 32'd0);
        check("post_rst_q", 32'(quotient), 32'h000E);
        check("post_rst_r", 32'(remainder), 32'h0002);

        // error right after reset result keeps the fresh result
        run_op(1'b0, 1'b0, 16'h0000, 16'h0300, 16'h0002, dEdge, bBad);
        check("hold_edge", 32'(dEdge), 32'd2);
        check("hold_err", 32'(divError), 32'd1);
        check("hold_q", 32'(quotient), 32'h000E);
        check("hold_r", 32'(remainder), 32'h0002);

        @(posedge CLKx4);
        #1;
        check("done_pulse_clears", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
